// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_controller
// Purpose  : Sequences the A09 CPU. Generates the CPU reset, Ready and the
//            single-cycle CPU clock-enable. Pulses come from a debounced
//            step button (step mode) or from a free-running divider (run
//            mode). A CPU halt parks the CPU; a step press restarts it.
// Ports    : Clk          system clock (16 MHz)
//            Reset        asynchronous active-low reset
//            StepBtn      raw step button, asynchronous, active-high
//            RunMode      raw mode switch, asynchronous (1 = run, 0 = step)
//            Halt         CPU halt indication, synchronous to Clk
//            CpuReset_n   CPU reset, active-low
//            CpuClkEn     one-cycle CPU advance pulse
//            Ready        CPU permitted to execute
//            CycleCount   saturating count of CpuClkEn since last CPU reset
//            ActivityLed  toggles on every CpuClkEn pulse
// Revision : 1.0  initial release
// ============================================================================
module cpu_run_controller #(
  parameter logic [15:0] DebounceCycles  = 16'd48000,
  parameter logic [22:0] DividerMax      = 23'd7999999,
  parameter int unsigned ResetHoldCycles = 4,
  parameter int unsigned CountWidth      = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  StepBtn,
  input  logic                  RunMode,
  input  logic                  Halt,
  output logic                  CpuReset_n,
  output logic                  CpuClkEn,
  output logic                  Ready,
  output logic [CountWidth-1:0] CycleCount,
  output logic                  ActivityLed
);

  localparam int unsigned c_HOLD_W = (ResetHoldCycles > 1) ? $clog2(ResetHoldCycles) : 1;
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(ResetHoldCycles - 1);
  localparam logic [15:0] c_DB_LAST = DebounceCycles - 16'd1;
  localparam logic [CountWidth-1:0] c_COUNT_MAX = {CountWidth{1'b1}};

  typedef enum logic [1:0] {
    ST_RESET_HOLD = 2'd0,
    ST_IDLE       = 2'd1,
    ST_RUN        = 2'd2,
    ST_HALTED     = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_clk_en_nxt;
  logic                  w_div_clr;

  logic [1:0]            r_step_sync;
  logic [1:0]            r_mode_sync;
  logic [15:0]           r_db_cnt;
  logic                  r_db_level;
  logic                  r_db_level_d;
  logic                  r_step_req;
  logic [22:0]           r_div;
  logic [c_HOLD_W-1:0]   r_hold_cnt;
  logic                  r_cpu_reset_n;
  logic                  r_clk_en;
  logic                  r_ready;
  logic [CountWidth-1:0] r_cycle_count;
  logic                  r_led;

  logic                  w_step_s;
  logic                  w_run_mode;

  assign w_step_s   = r_step_sync[1];
  assign w_run_mode = r_mode_sync[1];

  // Input synchronizers, button debounce and step-request edge detect.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_step_sync  <= 2'b00;
      r_mode_sync  <= 2'b00;
      r_db_cnt     <= 16'd0;
      r_db_level   <= 1'b0;
      r_db_level_d <= 1'b0;
      r_step_req   <= 1'b0;
    end else begin
      r_step_sync  <= {r_step_sync[0], StepBtn};
      r_mode_sync  <= {r_mode_sync[0], RunMode};
      if (w_step_s != r_db_level) begin
        // Accept the new level only after it has differed for the full window.
        if (r_db_cnt == c_DB_LAST) begin
          r_db_level <= w_step_s;
          r_db_cnt   <= 16'd0;
        end else begin
          r_db_cnt   <= r_db_cnt + 16'd1;
        end
      end else begin
        r_db_cnt <= 16'd0;
      end
      r_db_level_d <= r_db_level;
      r_step_req   <= r_db_level & ~r_db_level_d;
    end
  end

  // State register plus counters and registered outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state       <= ST_RESET_HOLD;
      r_hold_cnt    <= '0;
      r_div         <= 23'd0;
      r_cpu_reset_n <= 1'b0;
      r_clk_en      <= 1'b0;
      r_ready       <= 1'b0;
      r_cycle_count <= '0;
      r_led         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == ST_RESET_HOLD) && (w_state_nxt == ST_RESET_HOLD)) begin
        r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
      end else begin
        r_hold_cnt <= '0;
      end

      if (w_div_clr) begin
        r_div <= 23'd0;
      end else begin
        r_div <= r_div + 23'd1;
      end

      // Outputs follow the next state so they line up with the registered state.
      r_cpu_reset_n <= (w_state_nxt != ST_RESET_HOLD);
      r_ready       <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RUN);
      r_clk_en      <= w_clk_en_nxt;

      if (w_state_nxt == ST_RESET_HOLD) begin
        r_cycle_count <= '0;
      end else if (w_clk_en_nxt && (r_cycle_count != c_COUNT_MAX)) begin
        r_cycle_count <= r_cycle_count + CountWidth'(1);
      end

      if (w_clk_en_nxt) begin
        r_led <= ~r_led;
      end
    end
  end

  // Next-state and pulse decision. Halt outranks mode changes and pulses.
  always_comb begin
    w_state_nxt  = r_state;
    w_clk_en_nxt = 1'b0;
    w_div_clr    = 1'b1;
    case (r_state)
      ST_RESET_HOLD: begin
        if (r_hold_cnt == c_HOLD_LAST) begin
          w_state_nxt = w_run_mode ? ST_RUN : ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (Halt) begin
          w_state_nxt = ST_HALTED;
        end else if (w_run_mode) begin
          // A step request coinciding with the switch to run is dropped.
          w_state_nxt = ST_RUN;
        end else if (r_step_req) begin
          w_clk_en_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (Halt) begin
          w_state_nxt = ST_HALTED;
        end else if (!w_run_mode) begin
          w_state_nxt = ST_IDLE;
        end else if (r_div == DividerMax) begin
          w_clk_en_nxt = 1'b1;
        end else begin
          w_div_clr = 1'b0;
        end
      end
      ST_HALTED: begin
        if (r_step_req) begin
          w_state_nxt = ST_RESET_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_RESET_HOLD;
      end
    endcase
  end

  assign CpuReset_n  = r_cpu_reset_n;
  assign CpuClkEn    = r_clk_en;
  assign Ready       = r_ready;
  assign CycleCount  = r_cycle_count;
  assign ActivityLed = r_led;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_controller
// Purpose  : Self-checking bench for cpu_run_controller. A main instance is
//            exercised through reset, step presses, run mode, halt and
//            restart; a second narrow-counter instance in run mode covers
//            CycleCount saturation.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_run_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step_btn = 1'b0;
  logic run_mode = 1'b0;
  logic halt = 1'b0;

  logic        cpu_reset_n;
  logic        cpu_clk_en;
  logic        ready;
  logic [15:0] cycle_count;
  logic        activity_led;

  logic        sat_reset_n;
  logic        sat_clk_en;
  logic        sat_ready;
  logic [2:0]  sat_count;
  logic        sat_led;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  int pulse_q[$];
  int sat_pulses = 0;
  int sat_last = -1;
  int sat_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle index of every main-instance CpuClkEn pulse.
  always @(negedge clk) begin
    if (cpu_clk_en) pulse_q.push_back(cyc);
  end

  always @(negedge clk) begin
    if (sat_clk_en) begin
      if (sat_last >= 0 && (cyc - sat_last) != 2) sat_bad++;
      sat_last = cyc;
      sat_pulses++;
    end
  end

  cpu_run_controller #(
    .DebounceCycles (16'd4),
    .DividerMax     (23'd9),
    .ResetHoldCycles(4),
    .CountWidth     (16)
  ) dut (
    .Clk        (clk),
    .Reset      (rst_n),
    .StepBtn    (step_btn),
    .RunMode    (run_mode),
    .Halt       (halt),
    .CpuReset_n (cpu_reset_n),
    .CpuClkEn   (cpu_clk_en),
    .Ready      (ready),
    .CycleCount (cycle_count),
    .ActivityLed(activity_led)
  );

  cpu_run_controller #(
    .DebounceCycles (16'd4),
    .DividerMax     (23'd1),
    .ResetHoldCycles(4),
    .CountWidth     (3)
  ) u_sat (
    .Clk        (clk),
    .Reset      (rst_n),
    .StepBtn    (1'b0),
    .RunMode    (1'b1),
    .Halt       (1'b0),
    .CpuReset_n (sat_reset_n),
    .CpuClkEn   (sat_clk_en),
    .Ready      (sat_ready),
    .CycleCount (sat_count),
    .ActivityLed(sat_led)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bouncy (or clean) press, long hold, bouncy release, quiet tail.
  task automatic press(input bit clean);
    if (!clean) for (int i = 0; i < 3; i++) begin step_btn = 1'($urandom_range(0, 1)); tick(1); end
    step_btn = 1'b1;
    tick(20);
    if (!clean) for (int i = 0; i < 3; i++) begin step_btn = 1'($urandom_range(0, 1)); tick(1); end
    step_btn = 1'b0;
    tick(12);
  endtask

  function automatic int min7(input int v);
    return (v > 7) ? 7 : v;
  endfunction

  initial begin
    int exp_count;
    bit exp_led;
    int lc;
    bit done;
    int base;
    int c;
    int kh;
    int p;
    int e;
    int n;
    int presses;
    bit r2;

    exp_count = 0;
    exp_led   = 1'b0;

    // Held in reset.
    tick(3);
    check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("rst_clk_en", 32'(cpu_clk_en), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_count", 32'(cycle_count), 32'd0);
    check("rst_led", 32'(activity_led), 32'd0);

    // Release: CPU reset stays low for the hold time, then step mode.
    rst_n = 1'b1;
    lc = (cpu_reset_n == 1'b0) ? 1 : 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(1);
      if (!cpu_reset_n) lc++;
      else done = 1'b1;
    end
    check("release_done", 32'(done), 32'd1);
    check("release_low_cycles", 32'(lc), 32'd4);
    check("idle_ready", 32'(ready), 32'd1);
    check("idle_count", 32'(cycle_count), 32'd0);
    check("idle_clk_en", 32'(cpu_clk_en), 32'd0);

    tick(4);
    @(negedge clk); #1;
    check("sat_mid_count", 32'(sat_count), 32'(min7(sat_pulses)));

    // Step presses in IDLE: exactly one pulse per press.
    presses = $urandom_range(2, 3);
    for (int k = 0; k < presses; k++) begin
      base = pulse_q.size();
      press(1'b0);
      exp_count++;
      exp_led = ~exp_led;
      check("step_pulses", 32'(pulse_q.size() - base), 32'd1);
      check("step_count", 32'(cycle_count), 32'(exp_count));
      check("step_led", 32'(activity_led), 32'(exp_led));
    end

    // Run mode: pulses every DividerMax+1 cycles from entry, halt on a terminal count.
    base = pulse_q.size();
    run_mode = 1'b1;
    c = cyc;
    kh = $urandom_range(4, 5);
    p = c + 3 + 10 * (kh + 1);   // sync (2) + transition (1), pulse index kh suppressed
    while (cyc < p - 1) tick(1);
    halt = 1'b1;
    tick(1);
    check("halt_ready", 32'(ready), 32'd0);
    check("halt_clk_en", 32'(cpu_clk_en), 32'd0);
    check("halt_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
    halt = 1'b0;
    for (int i = 0; i < 30; i++) begin
      run_mode = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1));
      tick(1);
    end
    @(negedge clk); #1;
    check("run_pulse_total", 32'(pulse_q.size() - base), 32'(kh));
    for (int i = 0; i < kh && (base + i) < pulse_q.size(); i++)
      check("run_pulse_time", 32'(pulse_q[base + i]), 32'(c + 3 + 10 * (i + 1)));
    exp_count += kh;
    if (kh % 2 == 1) exp_led = ~exp_led;
    check("halted_ready", 32'(ready), 32'd0);
    check("run_count", 32'(cycle_count), 32'(exp_count));
    check("run_led", 32'(activity_led), 32'(exp_led));

    // Restart from HALTED with a clean press.
    r2 = 1'($urandom_range(0, 1));
    run_mode = r2;
    halt = 1'b0;
    tick(5);
    base = pulse_q.size();
    step_btn = 1'b1;
    lc = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick(1);
      if (!cpu_reset_n) lc++;
      else if (lc > 0) done = 1'b1;
    end
    e = cyc;
    step_btn = 1'b0;
    check("restart_done", 32'(done), 32'd1);
    check("restart_low_cycles", 32'(lc), 32'd4);
    check("restart_ready", 32'(ready), 32'd1);
    check("restart_count", 32'(cycle_count), 32'd0);
    exp_count = 0;
    while (cyc < e + 25) tick(1);
    @(negedge clk); #1;
    n = pulse_q.size() - base;
    if (r2) begin
      check("resume_run_pulses", 32'(n), 32'd2);
      if (n >= 2) begin
        check("resume_run_first", 32'(pulse_q[base]), 32'(e + 10));
        check("resume_run_second", 32'(pulse_q[base + 1]), 32'(e + 20));
      end
      exp_count = 2;
    end else begin
      check("resume_idle_pulses", 32'(n), 32'd0);
      press(1'b0);
      check("resume_step_pulses", 32'(pulse_q.size() - base), 32'd1);
      exp_count = 1;
    end
    check("resume_count", 32'(cycle_count), 32'(exp_count));

    // Saturation of the narrow counter.
    run_mode = 1'b1;
    tick(25);
    @(negedge clk); #1;
    check("sat_count_max", 32'(sat_count), 32'd7);
    check("sat_enough_pulses", 32'(sat_pulses > 8), 32'd1);
    check("sat_spacing_errors", 32'(sat_bad), 32'd0);
    check("sat_led_parity", 32'(sat_led), 32'(sat_pulses % 2));

    // Asynchronous reset while running.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
    check("async_clk_en", 32'(cpu_clk_en), 32'd0);
    check("async_ready", 32'(ready), 32'd0);
    check("async_count", 32'(cycle_count), 32'd0);
    check("async_led", 32'(activity_led), 32'd0);
    check("async_sat_count", 32'(sat_count), 32'd0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
